// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared helpers for the async FIFO status logic
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 8;

  // Extended pointer width: one extra bit above the address width distinguishes full from empty.
  function automatic int ext_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Prefix XOR; valid for any Gray width up to 32 because unused upper bits are zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int s = 1; s < 32; s = s * 2) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

  typedef logic [ext_width(DEFAULT_DEPTH)-1:0] ext_ptr_t;

endpackage

// File: rtl/fifo_status_flags_sync.sv
// rtl/fifo_status_flags_sync.sv - multi-stage synchroniser for the remote Gray pointer
module gray_ptr_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ptr_async,
  output logic [WIDTH-1:0] ptr_sync
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= ptr_async;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign ptr_sync = chain[STAGES-1];

endmodule

// File: rtl/fifo_status_flags.sv
// rtl/fifo_status_flags.sv - registered full/empty/level/almost for one async FIFO side
// Optional sticky misuse flag on port error when FIFO_STATUS_ERROR_EN is defined.
module fifo_status_flags
  import fifo_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int ALMOST_MARGIN = 1,
  parameter bit IS_WRITE_SIDE = 1'b1,
  localparam int PW = $clog2(DEPTH),
  localparam int EW = ext_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [PW-1:0] remote_ptr,
  output logic          full,
  output logic          empty,
  output logic          almost,
  output logic [EW-1:0] level
`ifdef FIFO_STATUS_ERROR_EN
  ,
  output logic          error
`endif
);

  logic [PW-1:0] remote_gray;
  logic [PW-1:0] remote_bin;
  logic [PW-1:0] remote_bin_prev;
  logic [PW-1:0] delta;
  logic [EW-1:0] remote_ext, remote_ext_next;
  logic [EW-1:0] local_ext, local_ext_next;
  logic [EW-1:0] level_next;

  gray_ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .ptr_async (remote_ptr),
    .ptr_sync  (remote_gray)
  );

  // Unwrap the synced address into a free-running count; relies on < DEPTH movement per sample.
  always_comb begin
    remote_bin      = PW'(gray2bin(32'(remote_gray)));
    delta           = remote_bin - remote_bin_prev;
    remote_ext_next = remote_ext + EW'(delta);
    local_ext_next  = local_ext + EW'(enable);
    level_next      = IS_WRITE_SIDE ? (local_ext_next - remote_ext_next)
                                    : (remote_ext_next - local_ext_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remote_bin_prev <= '0;
      remote_ext      <= '0;
      local_ext       <= '0;
      level           <= '0;
      empty           <= 1'b1;
      full            <= 1'b0;
      almost          <= !IS_WRITE_SIDE;
    end else begin
      remote_bin_prev <= remote_bin;
      remote_ext      <= remote_ext_next;
      local_ext       <= local_ext_next;
      level           <= level_next;
      empty           <= (level_next == '0);
      full            <= (level_next == EW'(DEPTH));
      almost          <= IS_WRITE_SIDE ? (level_next >= EW'(DEPTH - ALMOST_MARGIN))
                                       : (level_next <= EW'(ALMOST_MARGIN));
    end
  end

`ifdef FIFO_STATUS_ERROR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if (enable && (IS_WRITE_SIDE ? full : empty)) begin
      error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_status_flags.sv
// tb/tb_fifo_status_flags.sv - directed bench driving one write-side and one read-side instance
module tb_fifo_status_flags;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_enable = 1'b0, rd_enable = 1'b0;
  logic [2:0] wr_remote = '0, rd_remote = '0;
  logic       wr_full, wr_empty, wr_almost, rd_full, rd_empty, rd_almost;
  logic [3:0] wr_level, rd_level;
`ifdef FIFO_STATUS_ERROR_EN
  logic       wr_error, rd_error;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fifo_status_flags #(.DEPTH(8), .SYNC_STAGES(2), .ALMOST_MARGIN(1), .IS_WRITE_SIDE(1'b1)) u_wr (
    .clk(clk), .reset(reset), .enable(wr_enable), .remote_ptr(wr_remote),
    .full(wr_full), .empty(wr_empty), .almost(wr_almost), .level(wr_level)
`ifdef FIFO_STATUS_ERROR_EN
    , .error(wr_error)
`endif
  );

  fifo_status_flags #(.DEPTH(8), .SYNC_STAGES(2), .ALMOST_MARGIN(1), .IS_WRITE_SIDE(1'b0)) u_rd (
    .clk(clk), .reset(reset), .enable(rd_enable), .remote_ptr(rd_remote),
    .full(rd_full), .empty(rd_empty), .almost(rd_almost), .level(rd_level)
`ifdef FIFO_STATUS_ERROR_EN
    , .error(rd_error)
`endif
  );

  function automatic logic [2:0] to_gray(input int b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    repeat (3) begin
      wr_remote = 3'($urandom);
      rd_remote = 3'($urandom);
      tick();
    end
    wr_remote = '0;
    rd_remote = '0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (wr_level !== 4'd0) begin bad++; $display("FAIL reset_wr_level got=%0d exp=0", wr_level); end
    total++; if (wr_empty !== 1'b1) begin bad++; $display("FAIL reset_wr_empty got=%b exp=1", wr_empty); end
    total++; if (wr_full !== 1'b0) begin bad++; $display("FAIL reset_wr_full got=%b exp=0", wr_full); end
    total++; if (wr_almost !== 1'b0) begin bad++; $display("FAIL reset_wr_almost got=%b exp=0", wr_almost); end
    total++; if (rd_almost !== 1'b1) begin bad++; $display("FAIL reset_rd_almost got=%b exp=1", rd_almost); end
    total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL reset_rd_empty got=%b exp=1", rd_empty); end
`ifdef FIFO_STATUS_ERROR_EN
    total++; if (wr_error !== 1'b0) begin bad++; $display("FAIL reset_wr_error got=%b exp=0", wr_error); end
`endif
    tick();
    total++; if (wr_level !== 4'd0) begin bad++; $display("FAIL post_reset_level got=%0d exp=0", wr_level); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      wr_enable = 1'b1;
      tick();
      wr_enable = 1'b0;
      total++; if (wr_level !== 4'(i)) begin bad++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, wr_level, i); end
      total++; if (wr_full !== (i == 8)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, wr_full, (i == 8)); end
      total++; if (wr_almost !== (i >= 7)) begin bad++; $display("FAIL fill_almost[%0d] got=%b exp=%b", i, wr_almost, (i >= 7)); end
      total++; if (wr_empty !== 1'b0) begin bad++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, wr_empty); end
    end
    tick();
    total++; if (wr_level !== 4'd8 || wr_full !== 1'b1) begin bad++; $display("FAIL fill_hold got level=%0d full=%b exp level=8 full=1", wr_level, wr_full); end
  endtask

  task automatic test_drain_propagation();
    do_reset();
    rd_remote = to_gray(1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++; if (rd_empty !== (c < 3)) begin bad++; $display("FAIL drain_empty[%0d] got=%b exp=%b", c, rd_empty, (c < 3)); end
      total++; if (rd_level !== ((c < 3) ? 4'd0 : 4'd1)) begin bad++; $display("FAIL drain_level1[%0d] got=%0d exp=%0d", c, rd_level, (c < 3) ? 0 : 1); end
    end
    total++; if (rd_almost !== 1'b1) begin bad++; $display("FAIL drain_almost_l1 got=%b exp=1", rd_almost); end
    rd_remote = to_gray(2);
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++; if (rd_level !== ((c < 3) ? 4'd1 : 4'd2)) begin bad++; $display("FAIL drain_level2[%0d] got=%0d exp=%0d", c, rd_level, (c < 3) ? 1 : 2); end
    end
    total++; if (rd_almost !== 1'b0 || rd_full !== 1'b0) begin bad++; $display("FAIL drain_flags_l2 got almost=%b full=%b exp almost=0 full=0", rd_almost, rd_full); end
  endtask

  task automatic test_wrap();
    int full_seen;
    full_seen = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr_enable = 1'b1;
      tick();
      wr_enable = 1'b0;
      if (wr_full === 1'b1) full_seen++;
      wr_remote = to_gray((i + 1) % 8);
      tick();
      if (wr_full === 1'b1) full_seen++;
    end
    repeat (4) tick();
    total++; if (full_seen !== 0) begin bad++; $display("FAIL wrap_spurious_full got=%0d exp=0", full_seen); end
    total++; if (wr_level !== 4'd0) begin bad++; $display("FAIL wrap_level got=%0d exp=0", wr_level); end
    total++; if (wr_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", wr_empty); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (4) begin
      wr_enable = 1'b1;
      tick();
    end
    wr_enable = 1'b0;
    total++; if (wr_level !== 4'd4) begin bad++; $display("FAIL simul_pre got=%0d exp=4", wr_level); end
    wr_remote = to_gray(1);
    tick();
    tick();
    total++; if (wr_level !== 4'd4) begin bad++; $display("FAIL simul_wait got=%0d exp=4", wr_level); end
    wr_enable = 1'b1;
    tick();
    wr_enable = 1'b0;
    total++; if (wr_level !== 4'd4) begin bad++; $display("FAIL simul_edge got=%0d exp=4", wr_level); end
    tick();
    total++; if (wr_level !== 4'd4) begin bad++; $display("FAIL simul_after got=%0d exp=4", wr_level); end
  endtask

`ifdef FIFO_STATUS_ERROR_EN
  task automatic test_error();
    int held;
    held = 0;
    do_reset();
    repeat (8) begin
      wr_enable = 1'b1;
      tick();
    end
    total++; if (wr_full !== 1'b1 || wr_error !== 1'b0) begin bad++; $display("FAIL err_pre got full=%b error=%b exp full=1 error=0", wr_full, wr_error); end
    tick();
    wr_enable = 1'b0;
    total++; if (wr_error !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", wr_error); end
    repeat (10) begin
      tick();
      if (wr_error === 1'b1) held++;
    end
    total++; if (held !== 10) begin bad++; $display("FAIL err_sticky got=%0d exp=10", held); end
    do_reset();
    total++; if (wr_error !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", wr_error); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain_propagation();
    test_wrap();
    test_simultaneous();
`ifdef FIFO_STATUS_ERROR_EN
    test_error();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
